// File: rtl/mac_kernel_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_kernel_seq
// Description : Sequential multiply-accumulate kernel. Captures NTAPS signed
//               input/weight pairs and a bias on start, accumulates one
//               product per clock, then shifts, optionally ReLUs and
//               saturates or truncates the accumulator into P.
// Ports       : clk      - clock, rising edge active
//               reset    - asynchronous active-high reset
//               start    - request a new operation (ignored while busy)
//               inputs   - packed signed samples, tap k at [k*NBITS +: NBITS]
//               weights  - packed signed weights, same packing as inputs
//               bias     - signed accumulator initial value
//               relu_en  - clamp negative results to zero
//               sat_en   - 1 = saturate to OUTW, 0 = keep low OUTW bits
//               busy     - high while an operation is in flight
//               done     - one-cycle pulse when P is updated
//               P        - registered signed result, held until next done
// Revision    : 1.0 - initial release
// ============================================================================
module mac_kernel_seq #(
    parameter int NBITS = 8,
    parameter int NTAPS = 9,
    parameter int ACCW  = 2 * NBITS + $clog2(NTAPS),
    parameter int OUTW  = NBITS,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NTAPS*NBITS-1:0]   inputs,
    input  logic [NTAPS*NBITS-1:0]   weights,
    input  logic [ACCW-1:0]          bias,
    input  logic                     relu_en,
    input  logic                     sat_en,
    output logic                     busy,
    output logic                     done,
    output logic [OUTW-1:0]          P
);

    // Tap index width; at least one bit so NTAPS=1 still has a legal vector.
    localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NTAPS - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_out  = 2'd2;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACCW-1:0] c_sat_max =
        $signed({{(ACCW - OUTW + 1){1'b0}}, {(OUTW - 1){1'b1}}});
    localparam logic signed [ACCW-1:0] c_sat_min = ~c_sat_max;

    logic [1:0]                 r_state;
    logic [IDXW-1:0]            r_idx;
    logic signed [ACCW-1:0]     r_acc;
    logic [NTAPS*NBITS-1:0]     r_inputs;
    logic [NTAPS*NBITS-1:0]     r_weights;
    logic                       r_relu_en;
    logic                       r_sat_en;
    logic                       r_done;
    logic [OUTW-1:0]            r_p;

    logic signed [NBITS-1:0]    w_in_arr [NTAPS];
    logic signed [NBITS-1:0]    w_wt_arr [NTAPS];
    logic signed [2*NBITS-1:0]  w_prod;
    logic signed [ACCW-1:0]     w_prod_ext;
    logic signed [ACCW-1:0]     w_shifted;
    logic signed [ACCW-1:0]     w_relu;
    logic [OUTW-1:0]            w_sat;
    logic [OUTW-1:0]            w_result;

    // Unpack the captured operand vectors so the active tap is a plain index.
    genvar k;
    generate
        for (k = 0; k < NTAPS; k++) begin : g_unpack
            assign w_in_arr[k] = $signed(r_inputs[k*NBITS +: NBITS]);
            assign w_wt_arr[k] = $signed(r_weights[k*NBITS +: NBITS]);
        end
    endgenerate

    // Full-precision signed product, then sign-extended to accumulator width.
    assign w_prod     = w_in_arr[r_idx] * w_wt_arr[r_idx];
    assign w_prod_ext = ACCW'(w_prod);

    // Output conversion: shift, then ReLU, then saturate or truncate.
    assign w_shifted = r_acc >>> SHIFT;
    assign w_relu    = (r_relu_en && w_shifted[ACCW-1]) ? '0 : w_shifted;

    always_comb begin
        w_sat = w_relu[OUTW-1:0];
        if (w_relu > c_sat_max) begin
            w_sat = c_sat_max[OUTW-1:0];
        end else if (w_relu < c_sat_min) begin
            w_sat = c_sat_min[OUTW-1:0];
        end
    end

    assign w_result = r_sat_en ? w_sat : w_relu[OUTW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_idle;
            r_idx     <= '0;
            r_acc     <= '0;
            r_inputs  <= '0;
            r_weights <= '0;
            r_relu_en <= 1'b0;
            r_sat_en  <= 1'b0;
            r_done    <= 1'b0;
            r_p       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_inputs  <= inputs;
                        r_weights <= weights;
                        r_relu_en <= relu_en;
                        r_sat_en  <= sat_en;
                        r_acc     <= $signed(bias);
                        r_idx     <= '0;
                        r_state   <= c_run;
                    end
                end
                c_run: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        r_state <= c_out;
                    end
                end
                c_out: begin
                    r_p     <= w_result;
                    r_done  <= 1'b1;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign busy = (r_state != c_idle);
    assign done = r_done;
    assign P    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mac_kernel_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_kernel_seq
// Description : Directed self-checking bench for mac_kernel_seq. A second
//               instance with SHIFT=2 shares all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_kernel_seq;

    localparam int NBITS = 8;
    localparam int NTAPS = 9;
    localparam int ACCW  = 2 * NBITS + $clog2(NTAPS);
    localparam int OUTW  = 8;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [NTAPS*NBITS-1:0] inputs;
    logic [NTAPS*NBITS-1:0] weights;
    logic [ACCW-1:0]        bias;
    logic                   relu_en;
    logic                   sat_en;
    logic                   busy;
    logic                   done;
    logic [OUTW-1:0]        P;
    logic                   busy2;
    logic                   done2;
    logic [OUTW-1:0]        P2;

    int n_checks;
    int n_errors;

    mac_kernel_seq #(
        .NBITS(NBITS), .NTAPS(NTAPS), .OUTW(OUTW), .SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .inputs(inputs),
        .weights(weights), .bias(bias), .relu_en(relu_en), .sat_en(sat_en),
        .busy(busy), .done(done), .P(P)
    );

    mac_kernel_seq #(
        .NBITS(NBITS), .NTAPS(NTAPS), .OUTW(OUTW), .SHIFT(2)
    ) dut_shift2 (
        .clk(clk), .reset(reset), .start(start), .inputs(inputs),
        .weights(weights), .bias(bias), .relu_en(relu_en), .sat_en(sat_en),
        .busy(busy2), .done(done2), .P(P2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int in_val, input int wt_val, input int b,
                           input logic relu, input logic sat);
        for (int i = 0; i < NTAPS; i++) begin
            inputs[i*NBITS +: NBITS]  = NBITS'(in_val);
            weights[i*NBITS +: NBITS] = NBITS'(wt_val);
        end
        bias    = ACCW'(b);
        relu_en = relu;
        sat_en  = sat;
    endtask

    // Stimulus of the basic case: inputs all 1, weights 1..9, bias 0.
    task automatic set_ramp();
        set_ops(1, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < NTAPS; i++) weights[i*NBITS +: NBITS] = NBITS'(i + 1);
    endtask

    // Counts edges until done, sampling #1 after each edge; bounded.
    task automatic wait_done(output int lat, output int busy_cycles);
        logic got;
        got = 1'b0;
        lat = 0;
        busy_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check_value("done_timeout", 0, 1);
        end
    endtask

    // Pulses start across one edge, then waits for the result.
    task automatic run_op(output int lat, output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, busy_cycles);
    endtask

    int lat;
    int bcy;
    int ndone;

    initial begin
        n_checks = 0;
        n_errors = 0;
        start    = 1'b0;
        reset    = 1'b1;
        set_ops(0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_P", P, 0);
        check_value("reset_done", done, 0);
        check_value("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Ramp weights: 1+2+...+9 = 45
        set_ramp();
        run_op(lat, bcy);
        check_value("ramp_P", $signed(P), 45);
        check_value("ramp_latency", lat, 10);
        check_value("ramp_busy_cycles", bcy, 10);
        check_value("ramp_busy_in_done", busy, 0);
        @(posedge clk);
        #1;
        check_value("done_one_cycle", done, 0);
        check_value("P_held", $signed(P), 45);

        // 9*127*127 = 145161: saturates to 127, truncates to 9
        set_ops(127, 127, 0, 1'b0, 1'b1);
        run_op(lat, bcy);
        check_value("max_sat_P", $signed(P), 127);
        set_ops(127, 127, 0, 1'b0, 1'b0);
        run_op(lat, bcy);
        check_value("max_trunc_P", $signed(P), 9);

        // -1 * 5 over 9 taps = -45
        set_ops(-1, 5, 0, 1'b1, 1'b1);
        run_op(lat, bcy);
        check_value("neg_relu_P", $signed(P), 0);
        set_ops(-1, 5, 0, 1'b0, 1'b1);
        run_op(lat, bcy);
        check_value("neg_sat_P", $signed(P), -45);

        // 9*6 - 100 = -46; shifted by 2 -> -12
        set_ops(2, 3, -100, 1'b0, 1'b1);
        run_op(lat, bcy);
        check_value("bias_P", $signed(P), -46);
        check_value("bias_shift2_P", $signed(P2), -12);

        // Reset during the 4th RUN cycle aborts with no done pulse.
        set_ramp();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_value("abort_P", $signed(P), 0);
        check_value("abort_done", done, 0);
        check_value("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_value("abort_no_done", ndone, 0);
        run_op(lat, bcy);
        check_value("post_reset_P", $signed(P), 45);
        check_value("post_reset_latency", lat, 10);

        // start and operand changes while busy are ignored.
        set_ramp();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        set_ops(127, 127, 50, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcy);
        check_value("busy_ignore_P", $signed(P), 45);
        check_value("busy_ignore_latency", lat, 7);
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_value("busy_start_not_queued", ndone, 0);

        // start during the done cycle is accepted; second result 11 cycles later.
        set_ramp();
        run_op(lat, bcy);
        check_value("b2b_first_P", $signed(P), 45);
        start = 1'b1;
        set_ops(2, 3, -100, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcy);
        check_value("b2b_interval", lat + 1, 11);
        check_value("b2b_second_P", $signed(P), -46);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_kernel_seq.md
MAC_KERNEL_SEQ -- requirements
Module: mac_kernel_seq

Interface
REQ-001 Parameter NBITS, default 8: width of each signed input and weight sample.
REQ-002 Parameter NTAPS, default 9: number of input/weight pairs per operation; legal range 1..64.
REQ-003 Parameter ACCW, default 2*NBITS+$clog2(NTAPS): signed accumulator width.
REQ-004 Parameter OUTW, default NBITS: signed result width.
REQ-005 Parameter SHIFT, default 0: arithmetic right shift applied to the final accumulator before output conversion.
REQ-006 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-007 reset  input  1: asynchronous, active-high reset.
REQ-008 start  input  1: request a new operation.
REQ-009 inputs  input  NTAPS*NBITS: packed signed samples; tap k occupies bits [k*NBITS +: NBITS].
REQ-010 weights  input  NTAPS*NBITS: packed signed weights, same packing as inputs.
REQ-011 bias  input  ACCW: signed accumulator initial value.
REQ-012 relu_en  input  1: clamp negative results to zero.
REQ-013 sat_en  input  1: 1 = saturate to OUTW; 0 = truncate to the low OUTW bits.
REQ-014 busy  output  1: high whenever the FSM is not IDLE.
REQ-015 done  output  1: one-cycle pulse marking a valid P.
REQ-016 P  output  OUTW: registered signed result, held until the next done.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and OUT.
REQ-018 IDLE with start=1 at an edge SHALL:
  - capture inputs, weights, bias, relu_en and sat_en into internal registers;
  - load acc <= bias and tap index <= 0;
  - move to RUN.
REQ-019 In RUN, each edge SHALL:
  - add the sign-extended full-precision product of captured tap[idx] and weight[idx] to acc;
  - increment idx;
  - on idx == NTAPS-1, move to OUT.
REQ-020 In OUT, one edge SHALL:
  - register P from acc using REQ-021 to REQ-023;
  - set done=1 for exactly one cycle;
  - return to IDLE.
REQ-021 Output conversion order SHALL be: arithmetic shift right by SHIFT, then ReLU if captured relu_en, then saturate or truncate.
REQ-022 Saturation SHALL clamp to [-2^(OUTW-1), 2^(OUTW-1)-1].
REQ-023 Truncation SHALL keep bits [OUTW-1:0] unchanged.
REQ-024 Latency: done SHALL be high after the (NTAPS+1)th rising edge following the edge that accepted start.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 Operand changes while busy SHALL not affect the in-flight result.
REQ-027 start=1 during the done cycle SHALL be accepted; back-to-back throughput is one operation per NTAPS+2 cycles.
REQ-028 start held high continuously SHALL restart an operation every NTAPS+2 cycles.
REQ-029 With the default ACCW, the accumulator SHALL never overflow; no overflow detection is required.
REQ-030 With NTAPS=1, the RUN state SHALL last exactly one edge.

Reset
REQ-031 While reset=1, the block SHALL force state IDLE, acc=0, idx=0, P=0, done=0 and busy=0, independent of clk.
REQ-032 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-033 The first start after reset deasserts SHALL behave as a fresh operation.

Verification
(All scenarios use NBITS=8, NTAPS=9, OUTW=8, SHIFT=0 unless stated.)
REQ-034 inputs all 1, weights 1..9, bias 0, relu_en=0, sat_en=1
  -> P=45, done high exactly 10 edges after the accepting edge, busy high for 10 cycles.
REQ-035 inputs all 127, weights all 127, bias 0
  -> sat_en=1 gives P=127; sat_en=0 gives P=9 (145161 mod 256).
REQ-036 inputs all -1, weights all 5, bias 0
  -> relu_en=1 gives P=0; relu_en=0 with sat_en=1 gives P=-45.
REQ-037 inputs all 2, weights all 3, bias -100, sat_en=1
  -> P=-46.
  Same stimulus with SHIFT=2 -> P=-12.
REQ-038 reset pulsed during the 4th RUN cycle
  -> P=0, done=0, busy=0 immediately; a following start with the REQ-034 stimulus yields P=45.
REQ-039 start re-asserted and operands changed while busy
  -> request ignored and result unchanged.
  start asserted during the done cycle -> second result follows 11 cycles after the first.
